// File: rtl/fb_ahb_writer.sv
// AHB-Lite write master: streams NUM_PIXELS words from the transfer stage to BASE_ADDR upward.
// Optional INCR burst signalling is enabled by defining FB_AHB_INCR_BURST_EN.
`ifndef WIDTH
`define WIDTH 320
`endif
`ifndef HEIGHT
`define HEIGHT 240
`endif

module fb_ahb_writer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_PIXELS = `WIDTH * `HEIGHT,
  parameter int          CNT_W      = $clog2(NUM_PIXELS + 1)
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] pixel_data,
  output logic        ready_for_data,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_XFER,
    S_LAST,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             error_q, error_d;
  logic [31:0]      addr;
  logic             data_phase;
  logic             bus_err;

  assign addr = BASE_ADDR + (32'(cnt_q) << 2);

  // A data phase is outstanding once the first address has been accepted.
  assign data_phase = ((state_q == S_XFER) && (cnt_q != '0)) || (state_q == S_LAST);
  assign bus_err    = data_phase && HRESP;

  assign HSIZE  = 3'b010;
  assign HWDATA = wdata_q;
  assign busy   = (state_q != S_IDLE);
  assign error  = error_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wdata_d        = wdata_q;
    error_d        = error_q;
    ready_for_data = 1'b0;
    frame_done     = 1'b0;
    HADDR          = addr;
    HTRANS         = TRANS_IDLE;
    HWRITE         = 1'b0;
    HBURST         = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (start && !error_q) state_d = S_KICK;
      end
      S_KICK: begin
        ready_for_data = 1'b1;
        cnt_d          = '0;
        state_d        = S_XFER;
      end
      S_XFER: begin
        HWRITE = 1'b1;
`ifdef FB_AHB_INCR_BURST_EN
        HBURST = 3'b001;
        HTRANS = ((cnt_q == '0) || (addr[9:0] == 10'd0)) ? TRANS_NONSEQ : TRANS_SEQ;
`else
        HTRANS = TRANS_NONSEQ;
`endif
        if (bus_err) begin
          state_d = S_ERR;
        end else if (HREADY) begin
          ready_for_data = 1'b1;
          wdata_d        = pixel_data;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (bus_err)     state_d = S_ERR;
        else if (HREADY) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        cnt_d      = '0;
        wdata_d    = '0;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        // Counter and data are cleared so IDLE presents the reset bus values.
        cnt_d   = '0;
        wdata_d = '0;
        if (HREADY) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_fb_ahb_writer.sv
// Bench for fb_ahb_writer: random source words, bus-level write capture compared with the ideal
// frame (word i written to BASE+4*i), plus cycle-exact checks of the documented timing.
module tb_fb_ahb_writer;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] BASE_B = 32'h0000_03F8;

  logic        clk = 1'b0;
  logic        n_rst, start, start_b, HREADY, HRESP;
  logic [31:0] pixel_data;

  logic        ready_for_data, HWRITE, busy, frame_done, error;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;

  logic        ready_for_data_b, HWRITE_b, busy_b, frame_done_b, error_b;
  logic [31:0] HADDR_b, HWDATA_b;
  logic [1:0]  HTRANS_b;
  logic [2:0]  HSIZE_b, HBURST_b;

  always #5 clk = ~clk;

  fb_ahb_writer #(.BASE_ADDR(BASE), .NUM_PIXELS(N)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pixel_data(pixel_data),
    .ready_for_data(ready_for_data), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .frame_done(frame_done), .error(error)
  );

  fb_ahb_writer #(.BASE_ADDR(BASE_B), .NUM_PIXELS(N)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .pixel_data(pixel_data),
    .ready_for_data(ready_for_data_b), .HADDR(HADDR_b), .HTRANS(HTRANS_b), .HWRITE(HWRITE_b),
    .HSIZE(HSIZE_b), .HBURST(HBURST_b), .HWDATA(HWDATA_b), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy_b), .frame_done(frame_done_b), .error(error_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] src [N];
  int          ptr;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic        dp_pend;
  logic [31:0] dp_addr;
  int          done_cnt;

  task automatic frame_init();
    for (int i = 0; i < N; i++) src[i] = $urandom;
    ptr = 0;
    pixel_data = 32'h0;
    wr_addr.delete();
    wr_data.delete();
    dp_pend = 1'b0;
    dp_addr = 32'h0;
    done_cnt = 0;
  endtask

  // Negedge sample; records every completed, error-free write on the bus.
  task automatic sample();
    @(negedge clk);
    if (dp_pend && HREADY) begin
      if (!HRESP) begin
        wr_addr.push_back(dp_addr);
        wr_data.push_back(HWDATA);
      end
      dp_pend = 1'b0;
    end
    if (HTRANS[1] && HREADY) begin
      dp_pend = 1'b1;
      dp_addr = HADDR;
    end
    if (frame_done) done_cnt++;
  endtask

  // Source: presents the next word in the cycle after each ready_for_data pulse.
  task automatic advance();
    logic r;
    r = ready_for_data;
    @(posedge clk);
    #1;
    if (r) begin
      pixel_data = (ptr < N) ? src[ptr] : 32'hDEAD_BEEF;
      ptr++;
    end
  endtask

  task automatic run_frame(input int stall_pct, input bit restart, output bit timed_out);
    bit seen;
    int after;
    seen = 1'b0;
    after = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 150; c++) begin
      start  = (c == 0) || (restart && (c == 3 || c == 5));
      HRESP  = 1'b0;
      HREADY = (stall_pct == 0 || c < 2) ? 1'b1 : ($urandom_range(99) >= 32'(stall_pct));
      sample();
      if (frame_done) seen = 1'b1;
      advance();
      if (seen) after++;
      if (after >= 12) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    HREADY = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    @(negedge clk);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans got %b exp 00", HTRANS); end
    checks++; if (HADDR !== BASE) begin errors++; $display("FAIL reset_haddr got %h exp %h", HADDR, BASE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", HWDATA); end
    checks++; if ({HWRITE, HBURST, HSIZE} !== 7'b0_000_010) begin errors++; $display("FAIL reset_ctrl got %b exp 0000010", {HWRITE, HBURST, HSIZE}); end
    checks++; if ({ready_for_data, busy, frame_done, error} !== 4'b0) begin errors++; $display("FAIL reset_status got %b exp 0000", {ready_for_data, busy, frame_done, error}); end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    frame_init();
  endtask

  task automatic test_basic();
    frame_init();
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      sample();
      checks++; if (ready_for_data !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL basic_rfd c=%0d got %b", c, ready_for_data); end
      checks++; if (busy !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
      checks++; if (frame_done !== (c == 7)) begin errors++; $display("FAIL basic_done c=%0d got %b", c, frame_done); end
      if (c >= 2 && c <= 5) begin
        checks++; if (HADDR !== BASE + 32'(4 * (c - 2)) || HTRANS !== 2'b10 || HWRITE !== 1'b1) begin
          errors++; $display("FAIL basic_addr c=%0d got %h/%b exp %h/10", c, HADDR, HTRANS, BASE + 32'(4 * (c - 2)));
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++; if (HWDATA !== src[c - 3]) begin errors++; $display("FAIL basic_wdata c=%0d got %h exp %h", c, HWDATA, src[c - 3]); end
      end
      advance();
    end
    start = 1'b0;
    checks++; if (wr_addr.size() != N) begin errors++; $display("FAIL basic_count got %0d exp %0d", wr_addr.size(), N); end
    else for (int i = 0; i < N; i++) begin
      checks++; if (wr_addr[i] !== BASE + 32'(4 * i) || wr_data[i] !== src[i]) begin
        errors++; $display("FAIL basic_write i=%0d got %h:%h exp %h:%h", i, wr_addr[i], wr_data[i], BASE + 32'(4 * i), src[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    frame_init();
    for (int c = 0; c < 13; c++) begin
      start  = (c == 0);
      HREADY = !(c == 4 || c == 5);
      sample();
      if (c == 4 || c == 5) begin
        checks++; if (HADDR !== BASE + 32'h8 || HWDATA !== src[1] || ready_for_data !== 1'b0) begin
          errors++; $display("FAIL wait_hold c=%0d got %h/%h/%b exp %h/%h/0", c, HADDR, HWDATA, ready_for_data, BASE + 32'h8, src[1]);
        end
      end
      checks++; if (frame_done !== (c == 9)) begin errors++; $display("FAIL wait_done c=%0d got %b", c, frame_done); end
      advance();
    end
    start = 1'b0;
    HREADY = 1'b1;
    checks++; if (wr_addr.size() != N || done_cnt != 1) begin errors++; $display("FAIL wait_count got %0d/%0d exp %0d/1", wr_addr.size(), done_cnt, N); end
    else for (int i = 0; i < N; i++) begin
      checks++; if (wr_addr[i] !== BASE + 32'(4 * i) || wr_data[i] !== src[i]) begin
        errors++; $display("FAIL wait_write i=%0d got %h:%h exp %h:%h", i, wr_addr[i], wr_data[i], BASE + 32'(4 * i), src[i]);
      end
    end
  endtask

  task automatic test_bus_error();
    frame_init();
    for (int c = 0; c < 12; c++) begin
      start  = (c == 0);
      HRESP  = (c == 5 || c == 6);
      HREADY = (c != 5);
      sample();
      if (c == 6) begin
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL err_htrans got %b exp 00", HTRANS); end
      end
      if (c == 8) begin
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_flag got %b/%b exp 1/0", error, busy); end
      end
      advance();
    end
    start = 1'b0;
    HRESP = 1'b0;
    HREADY = 1'b1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL err_no_done got %0d exp 0", done_cnt); end
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL err_count got %0d exp 2", wr_addr.size()); end
    for (int c = 0; c < 8; c++) begin
      start = (c == 1);
      sample();
      checks++; if (HTRANS !== 2'b00 || busy !== 1'b0 || error !== 1'b1) begin
        errors++; $display("FAIL err_locked c=%0d got %b/%b/%b exp 00/0/1", c, HTRANS, busy, error);
      end
      advance();
    end
    start = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", error); end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    frame_init();
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      if (c == 4) n_rst = 1'b0;
      sample();
      if (c == 4) begin
        checks++; if (HTRANS !== 2'b00 || busy !== 1'b0 || HADDR !== BASE) begin
          errors++; $display("FAIL rstmid_idle got %b/%b/%h exp 00/0/%h", HTRANS, busy, HADDR, BASE);
        end
      end
      advance();
    end
    start = 1'b0;
    n_rst = 1'b1;
    frame_init();
    run_frame(0, 1'b0, to);
    checks++; if (to || done_cnt != 1 || wr_addr.size() != N) begin
      errors++; $display("FAIL rstmid_restart got to=%0d done=%0d writes=%0d exp 0/1/%0d", to, done_cnt, wr_addr.size(), N);
    end else for (int i = 0; i < N; i++) begin
      checks++; if (wr_addr[i] !== BASE + 32'(4 * i) || wr_data[i] !== src[i]) begin
        errors++; $display("FAIL rstmid_write i=%0d got %h:%h exp %h:%h", i, wr_addr[i], wr_data[i], BASE + 32'(4 * i), src[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    frame_init();
    run_frame(0, 1'b1, to);
    checks++; if (to || done_cnt != 1 || wr_addr.size() != N || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start got to=%0d done=%0d writes=%0d busy=%b exp 0/1/%0d/0", to, done_cnt, wr_addr.size(), N, busy);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int f = 0; f < 6; f++) begin
      frame_init();
      run_frame(35, f[0], to);
      checks++; if (to || done_cnt != 1 || wr_addr.size() != N) begin
        errors++; $display("FAIL rand_frame f=%0d got to=%0d done=%0d writes=%0d exp 0/1/%0d", f, to, done_cnt, wr_addr.size(), N);
      end else for (int i = 0; i < N; i++) begin
        checks++; if (wr_addr[i] !== BASE + 32'(4 * i) || wr_data[i] !== src[i]) begin
          errors++; $display("FAIL rand_write f=%0d i=%0d got %h:%h exp %h:%h", f, i, wr_addr[i], wr_data[i], BASE + 32'(4 * i), src[i]);
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [31:0] ea;
    logic [1:0]  et;
    logic [2:0]  eb;
    frame_init();
    HREADY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start_b = (c == 0);
      sample();
      if (c == 1) begin
        checks++; if (ready_for_data_b !== 1'b1 || busy_b !== 1'b1) begin errors++; $display("FAIL burst_kick got %b/%b exp 1/1", ready_for_data_b, busy_b); end
      end
      if (c >= 2 && c <= 5) begin
        ea = BASE_B + 32'(4 * (c - 2));
`ifdef FB_AHB_INCR_BURST_EN
        et = (c == 2 || ea[9:0] == 10'd0) ? 2'b10 : 2'b11;
        eb = 3'b001;
`else
        et = 2'b10;
        eb = 3'b000;
`endif
        checks++; if (HADDR_b !== ea || HTRANS_b !== et || HBURST_b !== eb || HWRITE_b !== 1'b1 || HSIZE_b !== 3'b010) begin
          errors++; $display("FAIL burst_beat c=%0d got %h/%b/%b exp %h/%b/%b", c, HADDR_b, HTRANS_b, HBURST_b, ea, et, eb);
        end
      end
      checks++; if (frame_done_b !== (c == 7)) begin errors++; $display("FAIL burst_done c=%0d got %b", c, frame_done_b); end
      advance();
    end
    start_b = 1'b0;
    checks++; if (HWDATA_b !== 32'h0 || error_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL burst_idle got %h/%b/%b exp 0/0/0", HWDATA_b, error_b, busy_b);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    start_b = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    frame_init();
    test_reset();
    test_basic();
    test_wait_states();
    test_bus_error();
    test_reset_mid_frame();
    test_start_while_busy();
    test_random();
    test_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
